dds_sweep_ctrl: RTL

- Frequency-sweep sequencer that sits directly upstream of the DDS test core and drives its control inputs: tuning word P, val_in, rst_ac and ena_ac.
- Steps the tuning word from a start value to a stop value in fixed increments, holding each point for a programmable dwell time.
- Modes: single, continuous and triangular (up/down) sweeps, plus abort and done/busy status for the host or test sequencer.

---
 rtl/dds_sweep_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/dds_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dds_sweep_ctrl
// Brief    : Frequency-sweep sequencer driving the DDS tuning word and
//            accumulator controls (single / continuous / triangular sweeps).
// Revision : 1.0 - initial release
// ============================================================================
module dds_sweep_ctrl #(
    parameter int M  = 27,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic          cont,
    input  logic          tri_en,   // "tri" is a reserved word in SystemVerilog
    input  logic [M-1:0]  p_start,
    input  logic [M-1:0]  p_stop,
    input  logic [M-1:0]  p_step,
    input  logic [DW-1:0] dwell,
    output logic [M-1:0]  P,
    output logic          val_in,
    output logic          rst_ac,
    output logic          ena_ac,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRIME = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [M-1:0]  r_start, r_stop, r_step;
    logic [DW-1:0] r_dwell_m1;
    logic          r_cont, r_tri, r_down;
    logic [DW-1:0] r_cnt, w_cnt;
    logic          w_down, w_cap, w_finish;
    logic [M-1:0]  w_p;
    logic          w_val, w_rst_ac, w_ena, w_busy, w_done;

    // One extra bit so neither leg can wrap around the M-bit range.
    logic [M:0] w_up, w_dn, w_rearm;
    logic       w_up_end, w_dn_end;

    assign w_up     = {1'b0, P} + {1'b0, r_step};
    assign w_dn     = {1'b0, P} - {1'b0, r_step};
    assign w_rearm  = {1'b0, r_start} + {1'b0, r_step};
    assign w_up_end = (w_up > {1'b0, r_stop}) || (r_step == '0);
    assign w_dn_end = w_dn[M] || (w_dn[M-1:0] < r_start);

    always_comb begin
        w_state_nxt = r_state;
        w_p         = P;
        w_val       = 1'b0;
        w_rst_ac    = 1'b0;
        w_ena       = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_cnt       = r_cnt;
        w_down      = r_down;
        w_cap       = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    w_state_nxt = S_PRIME;
                    w_cap       = 1'b1;
                    w_p         = p_start;
                    w_rst_ac    = 1'b1;
                    w_busy      = 1'b1;
                    w_down      = 1'b0;
                end
            end
            S_PRIME: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_RUN;
                    w_val       = 1'b1;
                    w_ena       = 1'b1;
                    w_busy      = 1'b1;
                    w_cnt       = r_dwell_m1;
                end
            end
            S_RUN: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_ena  = 1'b1;
                    w_busy = 1'b1;
                    if (r_cnt != '0) begin
                        w_cnt = r_cnt - DW'(1);
                    end else begin
                        w_val = 1'b1;
                        w_cnt = r_dwell_m1;
                        if (!r_down) begin
                            if (!w_up_end) begin
                                w_p = w_up[M-1:0];
                            end else if (r_tri && (P > r_start)) begin
                                w_down = 1'b1;
                                w_p    = w_dn[M-1:0];
                            end else if (r_cont) begin
                                w_p = r_start;
                            end else begin
                                w_finish = 1'b1;
                            end
                        end else begin
                            if (!w_dn_end) begin
                                w_p = w_dn[M-1:0];
                            end else if (r_cont) begin
                                w_down = 1'b0;
                                w_p    = (w_rearm > {1'b0, r_stop}) ? r_start : w_rearm[M-1:0];
                            end else begin
                                w_finish = 1'b1;
                            end
                        end
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (w_finish) begin
            w_state_nxt = S_DONE;
            w_p         = P;
            w_val       = 1'b0;
            w_ena       = 1'b0;
            w_busy      = 1'b0;
            w_done      = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            P       <= '0;
            val_in  <= 1'b0;
            rst_ac  <= 1'b0;
            ena_ac  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            r_cnt   <= '0;
            r_down  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            P       <= w_p;
            val_in  <= w_val;
            rst_ac  <= w_rst_ac;
            ena_ac  <= w_ena;
            busy    <= w_busy;
            done    <= w_done;
            r_cnt   <= w_cnt;
            r_down  <= w_down;
        end
    end

    // Sweep settings are frozen at an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start    <= '0;
            r_stop     <= '0;
            r_step     <= '0;
            r_dwell_m1 <= '0;
            r_cont     <= 1'b0;
            r_tri      <= 1'b0;
        end else if (w_cap) begin
            r_start    <= p_start;
            r_stop     <= p_stop;
            r_step     <= p_step;
            r_dwell_m1 <= (dwell == '0) ? '0 : dwell - DW'(1);
            r_cont     <= cont;
            r_tri      <= tri_en;
        end
    end

endmodule
`default_nettype wire
